aes_cbc_cipher_stream: RTL

//  Iterative AES-128 encryptor with a valid/ready stream interface and ECB/CBC chaining.
//  - One round per clock. Built from 16 S-box instances and the iterative AES-128 key expander.
//  - Sits between a plaintext block source and a ciphertext sink.
//  - The key and IV are loaded once; any number of blocks then streams through.
//  - A block counter is provided for software status.

---
 rtl/aes_cbc_cipher_stream.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/aes_cbc_cipher_stream.sv
// aes_cbc_cipher_stream: iterative AES-128 encryptor, one round per clock, ECB/CBC over a valid/ready stream
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };
    assign y = SBOX[a];
endmodule

module aes_key_exp (
    input  logic         clk,
    input  logic         rst,
    input  logic         kld,
    input  logic         nxt,
    input  logic [127:0] key,
    output logic [127:0] rk
);
    logic [7:0]  rcon;
    logic [31:0] sw, t, n0, n1, n2, n3;
    for (genvar i = 0; i < 4; i++) begin : g_sb
        aes_sbox u_sb (.a(rk[8*i +: 8]), .y(sw[8*i +: 8]));
    end
    // SubWord commutes with RotWord, so rotate the substituted word
    assign t  = {sw[23:0], sw[31:24]} ^ {rcon, 24'h0};
    assign n0 = rk[127:96] ^ t;
    assign n1 = rk[95:64] ^ n0;
    assign n2 = rk[63:32] ^ n1;
    assign n3 = rk[31:0] ^ n2;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rk   <= '0;
            rcon <= '0;
        end else if (kld) begin
            rk   <= key;
            rcon <= 8'h01;
        end else if (nxt) begin
            rk   <= {n0, n1, n2, n3};
            rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        end
    end
endmodule

module aes_cbc_cipher_stream #(
    parameter bit CBC_EN    = 1'b1,
    parameter int BLK_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 key_ld,
    input  logic [127:0]         key,
    input  logic [127:0]         iv,
    input  logic                 mode_cbc,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [127:0]         in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [127:0]         out_data,
    output logic                 busy,
    output logic [BLK_CNT_W-1:0] blk_cnt
);
    typedef enum logic [2:0] {IDLE, LOAD, INIT, ROUND, FINAL, OUT} state_t;
    state_t       state, state_nxt;
    logic         key_vld, accept, load_ok, out_hs;
    logic [3:0]   rnd;
    logic [127:0] key_r, chain_r, text_r, st, rk, sb, sr, mc;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] x);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = x;
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    assign load_ok = key_ld && state == IDLE;
    assign accept  = in_valid && in_ready;
    assign out_hs  = state == OUT && out_ready;

    aes_key_exp u_kx (
        .clk(clk),
        .rst(rst),
        .kld(state == LOAD),
        .nxt(state == INIT || state == ROUND),
        .key(key_r),
        .rk(rk)
    );

    for (genvar i = 0; i < 16; i++) begin : g_sb
        aes_sbox u_sb (.a(st[8*i +: 8]), .y(sb[8*i +: 8]));
    end
    // byte 4c+r holds row r of column c; ShiftRows rotates row r left by r columns
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
        end
        assign mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? LOAD : IDLE;
            LOAD:    state_nxt = INIT;
            INIT:    state_nxt = ROUND;
            ROUND:   state_nxt = rnd == 4'd9 ? FINAL : ROUND;
            FINAL:   state_nxt = OUT;
            OUT:     state_nxt = out_ready ? (accept ? LOAD : IDLE) : OUT;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = key_vld && !key_ld && (state == IDLE || (state == OUT && out_ready));
        busy     = state inside {LOAD, INIT, ROUND, FINAL};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_vld   <= 1'b0;
            key_r     <= '0;
            chain_r   <= '0;
            text_r    <= '0;
            st        <= '0;
            rnd       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            blk_cnt   <= '0;
        end else begin
            if (load_ok) begin
                key_r   <= key;
                key_vld <= 1'b1;
            end
            if (accept) text_r <= in_data ^ ((CBC_EN && mode_cbc) ? chain_r : '0);
            if (state == INIT) begin
                st  <= text_r ^ rk;
                rnd <= 4'd1;
            end
            if (state == ROUND) begin
                st  <= mc ^ rk;
                rnd <= rnd + 4'd1;
            end
            if (state == FINAL) begin
                out_data  <= sr ^ rk;
                out_valid <= 1'b1;
            end
            if (out_hs) out_valid <= 1'b0;
            chain_r <= load_ok ? iv : (state == FINAL ? sr ^ rk : chain_r);
            blk_cnt <= load_ok ? '0 : (out_hs ? blk_cnt + 1'b1 : blk_cnt);
        end
    end
endmodule
